// File: rtl/accessory_spi_master_pkg.sv
// Shared definitions for the accessory SPI master: FSM encoding, pin idle levels, length clamp.
package accessory_spi_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGap,
    StSetup,
    StSample,
    StDone
  } spi_state_e;

  localparam logic SckIdle  = 1'b0;
  localparam logic SsIdle   = 1'b1;
  localparam logic MosiIdle = 1'b1;

  // A length of zero or beyond the bus width means a full word.
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
    return ((len == 4'd0) || (len > max_len)) ? max_len : len;
  endfunction

endpackage

// File: rtl/accessory_spi_master_tick.sv
// CLK_DIV phase counter: flags the first and last cycle of each SCK half-period.
module accessory_spi_master_tick #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  output logic o_first,
  output logic o_last
);

  localparam int unsigned   CntW   = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || i_clear || o_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_first = (r_cnt == '0);
  assign o_last  = (r_cnt == CntMax);

endmodule

// File: rtl/accessory_spi_master.sv
// Mode-0, MSB-first SPI master for accessory controllers; 1..WORD_BYTES bytes per command,
// optional SS release between bytes.
module accessory_spi_master
  import accessory_spi_master_pkg::*;
#(
  parameter int unsigned WORD_BYTES  = 4,
  parameter int unsigned CLK_DIV     = 1,
  parameter int unsigned BYTE_GAP    = 32,
  parameter int unsigned TOGGLE_SS   = 1,
  parameter int unsigned MISO_INVERT = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [8*WORD_BYTES-1:0] tx_data,
  input  logic [3:0]              tx_len,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [8*WORD_BYTES-1:0] rx_data,
  output logic                    rx_valid,
  output logic                    busy,
  output logic                    sck,
  output logic                    ss,
  output logic                    mosi,
  input  logic                    miso
);

  localparam int unsigned     W            = 8 * WORD_BYTES;
  localparam logic [3:0]      WordBytesL   = 4'(WORD_BYTES);
  localparam int unsigned     GapW         = (BYTE_GAP < 2) ? 1 : $clog2(BYTE_GAP);
  localparam logic [GapW-1:0] GapLast      = GapW'(BYTE_GAP - 1);
  localparam logic            HasGap       = (BYTE_GAP != 0);
  localparam logic            GapEveryByte = (TOGGLE_SS != 0) && (BYTE_GAP != 0);
  localparam logic            MisoInv      = (MISO_INVERT != 0);

  spi_state_e      r_state, w_state_next;
  logic [W-1:0]    r_shift, r_rx_shift, r_rx_data, w_rx_mask;
  logic [6:0]      r_bit_cnt, w_bit_cnt_dec, w_shamt;
  logic [3:0]      r_len, w_len;
  logic [GapW-1:0] r_gap_cnt;
  logic            r_rx_valid;
  logic            w_rst, w_accept, w_tick_first, w_tick_last, w_tick_clear;

  assign w_rst         = reset || !enable;
  assign w_len         = clamp_len(tx_len, WordBytesL);
  assign w_shamt       = {WordBytesL - w_len, 3'b000};
  assign tx_ready      = enable && (r_state == StIdle);
  assign w_accept      = tx_valid && tx_ready && !reset;
  assign w_bit_cnt_dec = r_bit_cnt - 7'd1;
  assign w_tick_clear  = (w_state_next != r_state);

  accessory_spi_master_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clock  (clock),
    .reset  (w_rst),
    .i_clear(w_tick_clear),
    .o_first(w_tick_first),
    .o_last (w_tick_last)
  );

  always_ff @(posedge clock) begin
    if (w_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (w_accept) w_state_next = HasGap ? StGap : StSetup;
      StGap:    if (r_gap_cnt == GapLast) w_state_next = StSetup;
      StSetup:  if (w_tick_last) w_state_next = StSample;
      StSample: begin
        if (w_tick_last) begin
          if (w_bit_cnt_dec == 7'd0) begin
            w_state_next = StDone;
          end else if ((w_bit_cnt_dec[2:0] == 3'd0) && GapEveryByte) begin
            w_state_next = StGap;
          end else begin
            w_state_next = StSetup;
          end
        end
      end
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    sck  = SckIdle;
    ss   = SsIdle;
    mosi = MosiIdle;
    case (r_state)
      StSetup: begin
        ss   = 1'b0;
        mosi = r_shift[W-1];
      end
      StSample: begin
        sck  = 1'b1;
        ss   = 1'b0;
        mosi = r_shift[W-1];
      end
      default: ;
    endcase
  end

  // Bytes at or above the latched length are forced to zero in rx_data.
  always_comb begin
    w_rx_mask = '0;
    for (int b = 0; b < int'(WORD_BYTES); b++) begin
      w_rx_mask[8*b +: 8] = (4'(b) < r_len) ? 8'hFF : 8'h00;
    end
  end

  always_ff @(posedge clock) begin
    if (w_rst) begin
      r_shift    <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_bit_cnt  <= '0;
      r_len      <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_rx_valid <= (r_state == StDone);
      r_gap_cnt  <= (r_state == StGap) ? r_gap_cnt + GapW'(1) : '0;
      if (w_accept) begin
        r_shift    <= tx_data << w_shamt;
        r_rx_shift <= '0;
        r_bit_cnt  <= {w_len, 3'b000};
        r_len      <= w_len;
      end
      if ((r_state == StSample) && w_tick_first) begin
        r_rx_shift <= {r_rx_shift[W-2:0], miso ^ MisoInv};
      end
      if ((r_state == StSample) && w_tick_last) begin
        r_shift   <= {r_shift[W-2:0], 1'b0};
        r_bit_cnt <= w_bit_cnt_dec;
      end
      if (r_state == StDone) begin
        r_rx_data <= r_rx_shift & w_rx_mask;
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_accessory_spi_master.sv
// Directed bench: three configurations of accessory_spi_master driven from one sequence.
module tb_accessory_spi_master;

  localparam int N = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst [N];
  logic        en  [N];
  logic [31:0] txd [N];
  logic [3:0]  txl [N];
  logic        txv [N];
  logic        txr [N];
  logic [31:0] rxd [N];
  logic        rxv [N];
  logic        bsy [N];
  logic        sck [N];
  logic        ss  [N];
  logic        mosi[N];
  logic        miso[N];

  // Slaves on 0 and 1 echo ~mosi so the inverted capture returns the sent word.
  assign miso[0] = ~mosi[0];
  assign miso[1] = ~mosi[1];
  assign miso[2] = 1'b1;

  accessory_spi_master #(
    .WORD_BYTES(4), .CLK_DIV(1), .BYTE_GAP(32), .TOGGLE_SS(1), .MISO_INVERT(1)
  ) u_dut_a (
    .clock(clock), .reset(rst[0]), .enable(en[0]), .tx_data(txd[0]), .tx_len(txl[0]),
    .tx_valid(txv[0]), .tx_ready(txr[0]), .rx_data(rxd[0]), .rx_valid(rxv[0]), .busy(bsy[0]),
    .sck(sck[0]), .ss(ss[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  accessory_spi_master #(
    .WORD_BYTES(4), .CLK_DIV(3), .BYTE_GAP(4), .TOGGLE_SS(0), .MISO_INVERT(1)
  ) u_dut_b (
    .clock(clock), .reset(rst[1]), .enable(en[1]), .tx_data(txd[1]), .tx_len(txl[1]),
    .tx_valid(txv[1]), .tx_ready(txr[1]), .rx_data(rxd[1]), .rx_valid(rxv[1]), .busy(bsy[1]),
    .sck(sck[1]), .ss(ss[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  accessory_spi_master #(
    .WORD_BYTES(4), .CLK_DIV(1), .BYTE_GAP(0), .TOGGLE_SS(1), .MISO_INVERT(0)
  ) u_dut_c (
    .clock(clock), .reset(rst[2]), .enable(en[2]), .tx_data(txd[2]), .tx_len(txl[2]),
    .tx_valid(txv[2]), .tx_ready(txr[2]), .rx_data(rxd[2]), .rx_valid(rxv[2]), .busy(bsy[2]),
    .sck(sck[2]), .ss(ss[2]), .mosi(mosi[2]), .miso(miso[2])
  );

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          edges[N], sck_hi[N], ss_busy[N], bad_ready[N];
  int          acc_n[N], acc_cyc[N], rv_n[N], rv_cyc[N];
  logic [31:0] rv_data[N];
  logic        rv_ready[N];
  logic [63:0] stream[N];
  logic        prev_sck[N];

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (sck[i] && !prev_sck[i]) begin
        edges[i]++;
        stream[i] = {stream[i][62:0], mosi[i]};
      end
      prev_sck[i] = sck[i];
      if (sck[i]) sck_hi[i]++;
      if (bsy[i] && ss[i]) ss_busy[i]++;
      if (bsy[i] && txr[i]) bad_ready[i]++;
      if (txv[i] && txr[i] && !rst[i]) begin
        acc_n[i]++;
        acc_cyc[i] = cyc;
      end
      if (rxv[i]) begin
        rv_n[i]++;
        rv_cyc[i]   = cyc;
        rv_data[i]  = rxd[i];
        rv_ready[i] = txr[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr(input int i);
    edges[i] = 0; sck_hi[i] = 0; ss_busy[i] = 0; bad_ready[i] = 0;
    acc_n[i] = 0; acc_cyc[i] = 0; rv_n[i] = 0; rv_cyc[i] = 0;
    rv_data[i] = '0; rv_ready[i] = 1'b0; stream[i] = '0; prev_sck[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [31:0] d, input logic [3:0] l);
    step();
    txd[i] = d;
    txl[i] = l;
    txv[i] = 1'b1;
    step();
    txv[i] = 1'b0;
  endtask

  task automatic wait_rv(input int i, input int target, input int budget);
    int k = 0;
    while (rv_n[i] < target && k < budget) begin
      step();
      k++;
    end
    chk("rx_valid_count", 64'(rv_n[i]), 64'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; en[i] = 1'b1; txd[i] = '0; txl[i] = '0; txv[i] = 1'b0;
      clr(i);
    end
    repeat (3) step();
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    step();

    // Reset state
    chk("rst_sck", 64'(sck[0]), 64'd0);
    chk("rst_ss", 64'(ss[0]), 64'd1);
    chk("rst_mosi", 64'(mosi[0]), 64'd1);
    chk("rst_ready", 64'(txr[0]), 64'd1);
    chk("rst_busy", 64'(bsy[0]), 64'd0);
    chk("rst_rxvalid", 64'(rxv[0]), 64'd0);
    chk("rst_rxdata", 64'(rxd[0]), 64'd0);
    en[0] = 1'b0;
    #1;
    chk("disabled_ready", 64'(txr[0]), 64'd0);
    en[0] = 1'b1;
    step();

    // Full word, gaps with SS high
    clr(0);
    send(0, 32'h01A5C3F0, 4'd4);
    wait_rv(0, 1, 400);
    chk("t1_rx", 64'(rv_data[0]), 64'h01A5C3F0);
    chk("t1_latency", 64'(rv_cyc[0] - acc_cyc[0]), 64'd194);
    chk("t1_mosi", 64'(stream[0][31:0]), 64'h01A5C3F0);
    chk("t1_edges", 64'(edges[0]), 64'd32);
    chk("t1_ss_gap", 64'(ss_busy[0]), 64'd129);

    // Length clamping and single byte
    clr(0);
    send(0, 32'h12345678, 4'd0);
    wait_rv(0, 1, 400);
    chk("len0_rx", 64'(rv_data[0]), 64'h12345678);
    chk("len0_edges", 64'(edges[0]), 64'd32);
    clr(0);
    send(0, 32'hCAFEF00D, 4'd9);
    wait_rv(0, 1, 400);
    chk("len9_rx", 64'(rv_data[0]), 64'hCAFEF00D);
    chk("len9_edges", 64'(edges[0]), 64'd32);
    chk("len9_latency", 64'(rv_cyc[0] - acc_cyc[0]), 64'd194);
    clr(0);
    send(0, 32'hFFFFFF3C, 4'd1);
    wait_rv(0, 1, 200);
    chk("len1_rx", 64'(rv_data[0]), 64'h0000003C);
    chk("len1_mosi", 64'(stream[0][7:0]), 64'h3C);
    chk("len1_edges", 64'(edges[0]), 64'd8);
    chk("len1_latency", 64'(rv_cyc[0] - acc_cyc[0]), 64'd50);

    // Mid-transfer reset at the 10th SCK rising edge
    clr(0);
    send(0, 32'hA5A5A5A5, 4'd4);
    begin
      int k = 0;
      while (edges[0] < 10 && k < 400) begin
        step();
        k++;
      end
    end
    chk("abort_edge_reached", 64'(edges[0]), 64'd10);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("abort_sck", 64'(sck[0]), 64'd0);
    chk("abort_ss", 64'(ss[0]), 64'd1);
    chk("abort_mosi", 64'(mosi[0]), 64'd1);
    chk("abort_busy", 64'(bsy[0]), 64'd0);
    chk("abort_rxdata", 64'(rxd[0]), 64'd0);
    repeat (250) step();
    chk("abort_no_rxvalid", 64'(rv_n[0]), 64'd0);
    clr(0);
    send(0, 32'h0F0F55AA, 4'd4);
    wait_rv(0, 1, 400);
    chk("after_abort_rx", 64'(rv_data[0]), 64'h0F0F55AA);

    // tx_valid held high: back-to-back transfers
    clr(0);
    step();
    txd[0] = 32'h00000081;
    txl[0] = 4'd1;
    txv[0] = 1'b1;
    wait_rv(0, 2, 300);
    txv[0] = 1'b0;
    wait_rv(0, 3, 200);
    repeat (20) step();
    chk("b2b_accepts", 64'(acc_n[0]), 64'd3);
    chk("b2b_rxvalids", 64'(rv_n[0]), 64'd3);
    chk("b2b_ready_while_busy", 64'(bad_ready[0]), 64'd0);
    chk("b2b_ready_at_rxvalid", 64'(rv_ready[0]), 64'd1);
    chk("b2b_spacing", 64'(rv_cyc[0] - acc_cyc[0]), 64'd50);
    chk("b2b_rx", 64'(rv_data[0]), 64'h00000081);

    // SS held low, CLK_DIV=3, short word after a full one
    clr(1);
    send(1, 32'hDEADBEEF, 4'd4);
    wait_rv(1, 1, 400);
    chk("t2_full_rx", 64'(rv_data[1]), 64'hDEADBEEF);
    chk("t2_full_latency", 64'(rv_cyc[1] - acc_cyc[1]), 64'd198);
    clr(1);
    send(1, 32'h0000BEEF, 4'd2);
    wait_rv(1, 1, 300);
    chk("t2_rx", 64'(rv_data[1]), 64'h0000BEEF);
    chk("t2_latency", 64'(rv_cyc[1] - acc_cyc[1]), 64'd102);
    chk("t2_edges", 64'(edges[1]), 64'd16);
    chk("t2_sck_high", 64'(sck_hi[1]), 64'd48);
    chk("t2_ss_high", 64'(ss_busy[1]), 64'd5);
    chk("t2_mosi", 64'(stream[1][15:0]), 64'hBEEF);

    // No gap, non-inverted MISO tied high
    clr(2);
    send(2, 32'h5A5A5A5A, 4'd4);
    wait_rv(2, 1, 200);
    chk("t6_rx", 64'(rv_data[2]), 64'hFFFFFFFF);
    chk("t6_latency", 64'(rv_cyc[2] - acc_cyc[2]), 64'd66);
    chk("t6_ss_high", 64'(ss_busy[2]), 64'd1);
    chk("t6_mosi", 64'(stream[2][31:0]), 64'h5A5A5A5A);
    clr(2);
    send(2, 32'h000000C3, 4'd1);
    wait_rv(2, 1, 100);
    chk("t6_len1_rx", 64'(rv_data[2]), 64'h000000FF);
    chk("t6_len1_latency", 64'(rv_cyc[2] - acc_cyc[2]), 64'd18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
